time_display_ctrl: RTL
======================

// Module: time_display_ctrl
// PURPOSE
//  Timekeeping controller for the seven-segment clock display.
//  - Divides the board clock into a 1 Hz tick.
//  - Sequences cascaded BCD second/minute/hour digit counters (00:00:00..23:59:59).
//  - Runs a button-driven mode FSM that lets the user set hours and minutes.
//  - Feeds BCD digits and blink/status flags to the display mux/decoder stage.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per 1 Hz tick; legal range >= 2; bench uses 4
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  rst      in   1  synchronous reset, active-low
//  btn_mode in   1  debounced, synchronised mode button, active-high level
//  btn_inc  in   1  debounced, synchronised increment button, active-high level
//  hr10     out  2  hour tens BCD 0..2
//  hr1      out  4  hour units BCD 0..9; 0..3 when hr10==2
//  min10    out  3  minute tens BCD 0..5
//  min1     out  4  minute units BCD 0..9
//  sec10    out  3  second tens BCD 0..5
//  sec1     out  4  second units BCD 0..9
//  tick     out  1  one-cycle pulse each TICK_DIV cycles
//  set_hr   out  1  high while state==SET_HR
//  set_min  out  1  high while state==SET_MIN
//  blink    out  1  toggles on every tick in SET_HR/SET_MIN; 0 in RUN
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge):
//      all digits 0, prescaler 0, tick/blink 0, state RUN, button history regs 0.
//  - Prescaler:
//      counts 0..TICK_DIV-1; tick=1 in the cycle the count equals TICK_DIV-1, then wraps to 0.
//  - Button edges:
//      edge_x = btn_x & ~btn_x_q, with btn_x_q registered every cycle.
//      The action takes effect at the same clk edge, so outputs change 1 cycle after the input is first sampled high.
//      Holding a button high gives exactly one action.
//  - FSM states (2-bit): RUN=0, SET_HR=1, SET_MIN=2.
//      A mode edge steps RUN->SET_HR->SET_MIN->RUN; 3 is illegal and recovers to RUN on the next edge.
//  - RUN: on tick, sec1 increments.
//      sec 59->00 carries +1 into minutes in the same edge.
//      min 59->00 carries into hours.
//      hr 23->00 wraps with no carry out.
//      Hour unit limit: 9 when hr10<2, 3 when hr10==2 (so 09->10, 19->20, 23->00).
//  - SET_HR: time is frozen (ticks ignored for digits).
//      inc edge: hours +1, 23->00, no carry.
//  - SET_MIN: time is frozen.
//      inc edge: minutes +1, 59->00, no carry into hours.
//  - Leaving SET_MIN->RUN: sec10/sec1 cleared to 0, prescaler cleared to 0, blink cleared to 0.
//      The first RUN tick therefore arrives exactly TICK_DIV cycles later.
//  - The prescaler keeps running in the set states, for blink only.
//  - Simultaneous mode and inc edges: mode wins, inc is dropped.
//  - Simultaneous tick and mode edge in RUN: the tick increment is applied and the state moves to SET_HR.
//  - Reset mid-set: everything returns to the reset values; partially set time is lost.
//  - Digits never leave the legal BCD range; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared include time_defs.vh:
//      state encodings RUN/SET_HR/SET_MIN;
//      BCD limits SEC_MAX10=5, MIN_MAX10=5, HR_MAX10=2, HR_MAX1_AT2=3.
//  - One sub-module bcd_mod_counter:
//      two-digit BCD counter with inputs en, inc_only (suppress carry), limit;
//      outputs tens, units, carry.
//      Instantiated three times (sec, min, hr).
//      The hour instance takes a variable units limit.
//  - Top-level holds the prescaler, edge detectors and FSM.
// TESTING (TICK_DIV=4)
//  1 Hold rst=0 for 2 cycles with buttons toggling -> all digits 0, state RUN, tick/blink/set_* 0.
//  2 Run 240 cycles from reset -> 60 ticks, display 00:01:00; sec1 rolls 9->0 with a sec10 carry every 10 ticks.
//  3 Set 23:59 via mode + 23 hr incs + mode + 59 min incs + mode, then 4 cycles -> 23:59:01.
//    The next 59 ticks give 00:00:00, wrapping with no carry out.
//  4 In SET_HR, 24 inc edges from 00 -> hr back to 00, min/sec unchanged.
//    In SET_MIN, 60 inc edges -> min 00, hr unchanged.
//  5 btn_mode and btn_inc rise in the same cycle while in SET_HR -> state SET_MIN, hours unchanged.
//    Holding btn_inc high for 10 cycles -> exactly +1.
//  6 Reset pulse while in SET_MIN with hr=07 -> next cycle 00:00:00, RUN, blink 0.
//    Then tick and seconds resume from 0.

Source files
------------

// File: rtl/time_display_ctrl_pkg.sv
// Shared definitions for the clock display controller: mode encodings,
// BCD digit limits and the mode-button state sequence.
package time_display_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    localparam int         SEC_MAX10   = 5;
    localparam int         MIN_MAX10   = 5;
    localparam int         HR_MAX10    = 2;
    localparam logic [3:0] HR_MAX1_AT2 = 4'd3;
    localparam logic [3:0] UNIT_MAX    = 4'd9;

    // Mode button steps RUN -> SET_HR -> SET_MIN -> RUN.
    function automatic state_e next_mode(input state_e s);
        state_e n;
        case (s)
            RUN:     n = SET_HR;
            SET_HR:  n = SET_MIN;
            default: n = RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/time_display_ctrl_bcd_mod_counter.sv
// Two-digit BCD modulo counter used for seconds, minutes and hours.
// Ports: clk_i, rst_ni (sync, active-low), clr_i (force 00), en_i (+1),
//        inc_only_i (suppress carry), limit_i (units limit at top tens),
//        tens_o, units_o, carry_o (wrap to 00 this cycle).
module bcd_mod_counter
    import time_display_ctrl_pkg::*;
#(
    parameter int TW       = 3,
    parameter int TENS_MAX = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          inc_only_i,
    input  logic [3:0]    limit_i,
    output logic [TW-1:0] tens_o,
    output logic [3:0]    units_o,
    output logic          carry_o
);

    localparam logic [TW-1:0] TMAX = TW'(TENS_MAX);

    logic [TW-1:0] tens_q, tens_d;
    logic [3:0]    units_q, units_d;
    logic          at_units, at_top;

    // limit_i only applies on the top tens value; below it units run to 9.
    // Comparisons use >= so an out-of-range value still folds back to 00.
    assign at_units = (tens_q >= TMAX) ? (units_q >= limit_i)
                                       : (units_q >= UNIT_MAX);
    assign at_top   = at_units && (tens_q >= TMAX);

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr_i) begin
            tens_d  = '0;
            units_d = '0;
        end else if (en_i) begin
            if (at_top) begin
                tens_d  = '0;
                units_d = '0;
            end else if (at_units) begin
                tens_d  = tens_q + 1'b1;
                units_d = '0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    assign carry_o = en_i & ~inc_only_i & ~clr_i & at_top;
    assign tens_o  = tens_q;
    assign units_o = units_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/time_display_ctrl.sv
// Clock display controller: 1 Hz prescaler, button edge detect, mode FSM
// and cascaded BCD sec/min/hr counters (00:00:00..23:59:59).
// Ports: clk, rst (sync, active-low), btn_mode, btn_inc (level, synced);
//        hr10/hr1/min10/min1/sec10/sec1 BCD digits;
//        tick (1-cycle pulse), set_hr, set_min, blink status flags.
module time_display_ctrl
    import time_display_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] hr10,
    output logic [3:0] hr1,
    output logic [2:0] min10,
    output logic [3:0] min1,
    output logic [2:0] sec10,
    output logic [3:0] sec1,
    output logic       tick,
    output logic       set_hr,
    output logic       set_min,
    output logic       blink
);

    localparam int            CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;
    logic          mode_q, inc_q;

    logic          mode_edge, inc_edge, leave_set;
    logic          in_run, in_hr, in_min;
    logic          sec_en, min_en, hr_en;
    logic          sec_carry, min_carry, hr_carry_unused;
    logic [3:0]    hr_lim;

    assign tick      = (cnt_q == CNT_MAX);
    assign mode_edge = btn_mode & ~mode_q;
    // Mode has priority: an inc edge coinciding with a mode edge is dropped.
    assign inc_edge  = btn_inc & ~inc_q & ~mode_edge;

    assign in_run    = (state_q == RUN);
    assign in_hr     = (state_q == SET_HR);
    assign in_min    = (state_q == SET_MIN);
    assign leave_set = mode_edge & in_min;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, SET_HR, SET_MIN: begin
                if (mode_edge) state_d = next_mode(state_q);
            end
            default: state_d = RUN;
        endcase
    end

    // Returning to RUN restarts the prescaler so a full second elapses
    // before the first increment.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick || leave_set) cnt_d = '0;
    end

    always_comb begin
        blink_d = blink_q;
        if (tick && !in_run) blink_d = ~blink_q;
        if (state_d == RUN)  blink_d = 1'b0;
    end

    assign sec_en = in_run & tick;
    assign min_en = (in_run & sec_carry) | (in_min & inc_edge);
    assign hr_en  = (in_run & min_carry) | (in_hr & inc_edge);
    assign hr_lim = (hr10 == 2'(HR_MAX10)) ? HR_MAX1_AT2 : UNIT_MAX;

    bcd_mod_counter #(.TW(3), .TENS_MAX(SEC_MAX10)) u_sec (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (leave_set),
        .en_i       (sec_en),
        .inc_only_i (1'b0),
        .limit_i    (UNIT_MAX),
        .tens_o     (sec10),
        .units_o    (sec1),
        .carry_o    (sec_carry)
    );

    bcd_mod_counter #(.TW(3), .TENS_MAX(MIN_MAX10)) u_min (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (1'b0),
        .en_i       (min_en),
        .inc_only_i (in_min),
        .limit_i    (UNIT_MAX),
        .tens_o     (min10),
        .units_o    (min1),
        .carry_o    (min_carry)
    );

    // Hours wrap 23 -> 00 with nothing above them to carry into.
    bcd_mod_counter #(.TW(2), .TENS_MAX(HR_MAX10)) u_hr (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (1'b0),
        .en_i       (hr_en),
        .inc_only_i (1'b1),
        .limit_i    (hr_lim),
        .tens_o     (hr10),
        .units_o    (hr1),
        .carry_o    (hr_carry_unused)
    );

    assign set_hr  = in_hr;
    assign set_min = in_min;
    assign blink   = blink_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            mode_q  <= btn_mode;
            inc_q   <= btn_inc;
        end
    end

endmodule
